sp_wb_arbiter: RTL and testbench

SP_WB_ARBITER -- requirements
Module: sp_wb_arbiter

---
 rtl/sp_wb_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sp_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_wb_arbiter.sv
// Two-master to one-slave Wishbone classic arbiter (SP byte bridge + DMA/loader).
// Alternates on ties, never breaks a held cycle, and forces completion of a stalled slave.
//
// state  | meaning
// IDLE   | no master granted, all wb_* outputs low
// GRANT0 | master 0 owns the slave bus until it drops cyc
// GRANT1 | master 1 owns the slave bus until it drops cyc
module sp_wb_arbiter #(
    parameter logic [7:0] timeout = 8'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:23] m0_adr_i,
    input  logic [0:7]  m0_dat_i,
    input  logic        m0_we_i,
    input  logic        m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [0:7]  m0_dat_o,
    output logic        m0_ack_o,
    input  logic [23:0] m1_adr_i,
    input  logic [7:0]  m1_dat_i,
    input  logic        m1_we_i,
    input  logic        m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [7:0]  m1_dat_o,
    output logic        m1_ack_o,
    output logic [23:0] wb_adr_o,
    output logic [7:0]  wb_dat_o,
    output logic        wb_we_o,
    output logic        wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [7:0]  wb_dat_i,
    input  logic        wb_ack_i,
    output logic        timeout_flag,
    output logic [23:0] timeout_adr,
    input  logic        timeout_clr
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_grant;
    logic        w_last_grant_nxt;
    logic [7:0]  r_wait_cnt;
    logic        r_timeout_flag;
    logic [23:0] r_timeout_adr;

    logic        w_g0;
    logic        w_g1;
    logic [23:0] w_adr;
    logic [7:0]  w_dat;
    logic        w_we;
    logic        w_sel;
    logic        w_stb;
    logic        w_cyc;
    logic        w_force;
    logic        w_ack;
    logic [7:0]  w_rdat;

    // Grants are masked by reset so every output is quiet while reset is held.
    assign w_g0 = (r_state == GRANT0) && !reset;
    assign w_g1 = (r_state == GRANT1) && !reset;

    always_comb begin
        w_adr = 24'h000000;
        w_dat = 8'h00;
        w_we  = 1'b0;
        w_sel = 1'b0;
        w_stb = 1'b0;
        w_cyc = 1'b0;
        if (w_g0) begin
            w_adr = m0_adr_i;
            w_dat = m0_dat_i;
            w_we  = m0_we_i;
            w_sel = m0_sel_i;
            w_stb = m0_stb_i;
            w_cyc = m0_cyc_i;
        end else if (w_g1) begin
            w_adr = m1_adr_i;
            w_dat = m1_dat_i;
            w_we  = m1_we_i;
            w_sel = m1_sel_i;
            w_stb = m1_stb_i;
            w_cyc = m1_cyc_i;
        end
    end

    // A slave ack in the terminal cycle wins over the forced completion.
    assign w_force = (w_g0 || w_g1) && w_cyc && w_stb && !wb_ack_i
                     && (r_wait_cnt == timeout - 8'd1);
    assign w_ack   = (w_g0 || w_g1) && w_cyc && w_stb && (wb_ack_i || w_force);
    assign w_rdat  = w_force ? 8'hFF : wb_dat_i;

    assign wb_adr_o = w_adr;
    assign wb_dat_o = w_dat;
    assign wb_we_o  = w_we;
    assign wb_sel_o = w_sel;
    assign wb_cyc_o = w_cyc;
    assign wb_stb_o = w_stb && !w_force;

    assign m0_ack_o = w_g0 && w_ack;
    assign m0_dat_o = w_g0 ? w_rdat : 8'h00;
    assign m1_ack_o = w_g1 && w_ack;
    assign m1_dat_o = w_g1 ? w_rdat : 8'h00;

    assign timeout_flag = r_timeout_flag;
    assign timeout_adr  = r_timeout_adr;

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    w_state_nxt = r_last_grant ? GRANT0 : GRANT1;
                else if (m0_cyc_i)
                    w_state_nxt = GRANT0;
                else if (m1_cyc_i)
                    w_state_nxt = GRANT1;
            end
            GRANT0: begin
                if (!m0_cyc_i) begin
                    w_state_nxt      = m1_cyc_i ? GRANT1 : IDLE;
                    w_last_grant_nxt = 1'b0;
                end
            end
            GRANT1: begin
                if (!m1_cyc_i) begin
                    w_state_nxt      = m0_cyc_i ? GRANT0 : IDLE;
                    w_last_grant_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_wait_cnt <= 8'd0;
        else if (!(w_g0 || w_g1) || !w_cyc || !w_stb || wb_ack_i || w_force)
            r_wait_cnt <= 8'd0;
        else if (r_wait_cnt != 8'hFF)
            r_wait_cnt <= r_wait_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout_flag <= 1'b0;
            r_timeout_adr  <= 24'h000000;
        end else if (w_force) begin
            r_timeout_flag <= 1'b1;
            r_timeout_adr  <= w_adr;
        end else if (timeout_clr) begin
            r_timeout_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sp_wb_arbiter.sv
// Directed bench for sp_wb_arbiter (timeout = 8): grant latency, tie alternation,
// held cycles, forced completion, ack-at-terminal-count and mid-access reset.
module tb_sp_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:23] m0_adr_i;
    logic [0:7]  m0_dat_i;
    logic        m0_we_i, m0_sel_i, m0_stb_i, m0_cyc_i;
    logic [0:7]  m0_dat_o;
    logic        m0_ack_o;
    logic [23:0] m1_adr_i;
    logic [7:0]  m1_dat_i;
    logic        m1_we_i, m1_sel_i, m1_stb_i, m1_cyc_i;
    logic [7:0]  m1_dat_o;
    logic        m1_ack_o;
    logic [23:0] wb_adr_o;
    logic [7:0]  wb_dat_o;
    logic        wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o;
    logic [7:0]  wb_dat_i;
    logic        wb_ack_i;
    logic        timeout_flag;
    logic [23:0] timeout_adr;
    logic        timeout_clr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sp_wb_arbiter #(.timeout(8'd8)) dut (
        .clk(clk), .reset(reset),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .timeout_flag(timeout_flag), .timeout_adr(timeout_adr),
        .timeout_clr(timeout_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven and
    // outputs sampled 2 ns later, well away from either edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic m0_set(input logic cyc, input logic stb, input logic [23:0] adr, input logic we);
        m0_cyc_i = cyc; m0_stb_i = stb; m0_adr_i = adr; m0_we_i = we; m0_sel_i = cyc;
    endtask

    task automatic m1_set(input logic cyc, input logic stb, input logic [23:0] adr, input logic we);
        m1_cyc_i = cyc; m1_stb_i = stb; m1_adr_i = adr; m1_we_i = we; m1_sel_i = cyc;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nxt();
        nxt();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        m0_set(0, 0, 24'h0, 0); m0_dat_i = 8'h00;
        m1_set(0, 0, 24'h0, 0); m1_dat_i = 8'h00;
        wb_dat_i = 8'h00; wb_ack_i = 1'b0; timeout_clr = 1'b0;

        // Reset: outputs quiet during and after
        nxt();
        m0_set(1, 1, 24'h000055, 0);
        settle();
        check_eq("rst_cyc_during", wb_cyc_o, 0);
        check_eq("rst_ack_during", m0_ack_o, 0);
        nxt();
        reset = 1'b0;
        m0_set(0, 0, 24'h0, 0);
        settle();
        check_eq("rst_cyc_after", wb_cyc_o, 0);
        check_eq("rst_flag", timeout_flag, 0);
        check_eq("rst_tadr", timeout_adr, 24'h000000);

        // m0 read with 3 wait cycles, data 5A
        m0_set(1, 1, 24'h000123, 0);
        settle();
        check_eq("rd_idle_cyc", wb_cyc_o, 0);
        nxt();
        settle();
        check_eq("rd_grant_cyc", wb_cyc_o, 1);
        check_eq("rd_adr", wb_adr_o, 24'h000123);
        check_eq("rd_wait_ack", m0_ack_o, 0);
        nxt(); nxt();
        settle();
        check_eq("rd_wait3_ack", m0_ack_o, 0);
        nxt();
        wb_ack_i = 1'b1; wb_dat_i = 8'h5A;
        settle();
        check_eq("rd_ack", m0_ack_o, 1);
        check_eq("rd_dat", m0_dat_o, 8'h5A);
        check_eq("rd_m1_ack", m1_ack_o, 0);
        check_eq("rd_m1_dat", m1_dat_o, 8'h00);
        nxt();
        wb_ack_i = 1'b0; wb_dat_i = 8'h00;
        m0_set(0, 0, 24'h0, 0);
        nxt();
        settle();
        check_eq("rd_back_idle", wb_cyc_o, 0);

        // Tie after reset: m0 first, then m1 with no gap, then m0 again
        do_reset();
        m0_set(1, 1, 24'h000010, 0);
        m1_set(1, 1, 24'h000020, 0);
        nxt();
        wb_ack_i = 1'b1; wb_dat_i = 8'h11;
        settle();
        check_eq("tie_adr0", wb_adr_o, 24'h000010);
        check_eq("tie_m0_ack", m0_ack_o, 1);
        check_eq("tie_m1_ack0", m1_ack_o, 0);
        nxt();
        wb_ack_i = 1'b0;
        m0_set(0, 0, 24'h0, 0);
        nxt();
        wb_ack_i = 1'b1; wb_dat_i = 8'h22;
        settle();
        check_eq("tie_nogap_cyc", wb_cyc_o, 1);
        check_eq("tie_adr1", wb_adr_o, 24'h000020);
        check_eq("tie_m1_ack", m1_ack_o, 1);
        check_eq("tie_m1_dat", m1_dat_o, 8'h22);
        check_eq("tie_m0_ack1", m0_ack_o, 0);
        nxt();
        wb_ack_i = 1'b0;
        m1_set(0, 0, 24'h0, 0);
        nxt();
        m0_set(1, 1, 24'h000010, 0);
        m1_set(1, 1, 24'h000020, 0);
        nxt();
        settle();
        check_eq("tie2_adr0", wb_adr_o, 24'h000010);
        m0_set(0, 0, 24'h0, 0);
        m1_set(0, 0, 24'h0, 0);
        nxt();
        nxt();

        // m0 holds cyc across 4 accesses while m1 waits
        m0_set(1, 1, 24'h000100, 0);
        nxt();
        m1_set(1, 1, 24'h000200, 0);
        for (int i = 0; i < 4; i++) begin
            m0_adr_i = 24'h000100 + 24'(i);
            wb_ack_i = 1'b1; wb_dat_i = 8'hC0 + 8'(i);
            settle();
            check_eq($sformatf("hold_adr%0d", i), wb_adr_o, 24'h000100 + 24'(i));
            check_eq($sformatf("hold_ack%0d", i), m0_ack_o, 1);
            check_eq($sformatf("hold_dat%0d", i), m0_dat_o, 8'hC0 + 8'(i));
            check_eq($sformatf("hold_m1%0d", i), m1_ack_o, 0);
            nxt();
        end
        wb_ack_i = 1'b0;
        m0_set(0, 0, 24'h0, 0);
        nxt();
        wb_ack_i = 1'b1;
        settle();
        check_eq("hold_m1_adr", wb_adr_o, 24'h000200);
        check_eq("hold_m1_ack", m1_ack_o, 1);
        nxt();
        wb_ack_i = 1'b0;
        m1_set(0, 0, 24'h0, 0);
        nxt();

        // m1 write, slave never acks: forced completion on 8th stb cycle
        m1_set(1, 1, 24'hABCDEF, 1); m1_dat_i = 8'h3C;
        nxt();
        for (int k = 1; k < 8; k++) begin
            settle();
            check_eq($sformatf("to_wait_ack%0d", k), m1_ack_o, 0);
            check_eq($sformatf("to_wait_stb%0d", k), wb_stb_o, 1);
            nxt();
        end
        timeout_clr = 1'b1;
        settle();
        check_eq("to_force_ack", m1_ack_o, 1);
        check_eq("to_force_stb", wb_stb_o, 0);
        check_eq("to_force_dat", m1_dat_o, 8'hFF);
        check_eq("to_wr_dat", wb_dat_o, 8'h3C);
        check_eq("to_wr_we", wb_we_o, 1);
        nxt();
        timeout_clr = 1'b0;
        m1_set(0, 0, 24'h0, 0);
        settle();
        check_eq("to_flag_set", timeout_flag, 1);
        check_eq("to_adr", timeout_adr, 24'hABCDEF);
        check_eq("to_ack_once", m1_ack_o, 0);
        timeout_clr = 1'b1;
        nxt();
        timeout_clr = 1'b0;
        settle();
        check_eq("to_flag_clr", timeout_flag, 0);
        check_eq("to_adr_keep", timeout_adr, 24'hABCDEF);

        // Ack arriving in the terminal-count cycle wins
        m0_set(1, 1, 24'h000777, 0);
        nxt();
        for (int k = 1; k < 8; k++) begin
            settle();
            check_eq($sformatf("tc_wait_ack%0d", k), m0_ack_o, 0);
            nxt();
        end
        wb_ack_i = 1'b1; wb_dat_i = 8'h96;
        settle();
        check_eq("tc_ack", m0_ack_o, 1);
        check_eq("tc_dat", m0_dat_o, 8'h96);
        check_eq("tc_stb", wb_stb_o, 1);
        nxt();
        wb_ack_i = 1'b0;
        m0_set(0, 0, 24'h0, 0);
        settle();
        check_eq("tc_flag", timeout_flag, 0);
        nxt();

        // Reset during an m1 wait aborts without ack
        m1_set(1, 1, 24'h000333, 0);
        nxt();
        nxt();
        nxt();
        reset = 1'b1;
        settle();
        check_eq("rw_during_cyc", wb_cyc_o, 0);
        check_eq("rw_during_ack", m1_ack_o, 0);
        nxt();
        reset = 1'b0;
        settle();
        check_eq("rw_after_cyc", wb_cyc_o, 0);
        check_eq("rw_after_ack", m1_ack_o, 0);
        check_eq("rw_flag", timeout_flag, 0);
        nxt();
        settle();
        check_eq("rw_restart_cyc", wb_cyc_o, 1);
        m1_set(0, 0, 24'h0, 0);
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
